topn_insert_buffer: RTL and testbench

//  Owns the descending-sorted top-N score table (slot 0 = highest) and its fill count. Feeds both to the

---
 rtl/topn_pkg.sv | 21 ++
 rtl/topn_insert_buffer.sv | 160 ++++++++++++++++
 tb/tb_topn_insert_buffer.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/topn_pkg.sv
// Shared definitions for the top-N insert buffer: FSM state encoding and
// the helper that picks the first slot touched by an insertion.
package topn_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_START    = 3'd1,
    ST_WAIT_CMP = 3'd2,
    ST_SHIFT    = 3'd3,
    ST_WRITE    = 3'd4,
    ST_DONE     = 3'd5,
    ST_DROP     = 3'd6
  } state_t;

  // Highest slot affected by an insertion. If the table is full this is the
  // last slot (its contents get evicted); otherwise it is the first free slot.
  function automatic int slot_top(input int num, input int qty);
    return (num < qty) ? num : qty - 1;
  endfunction

endpackage

// File: rtl/topn_insert_buffer.sv
// Descending-sorted top-N score table with a fill count. A new score is
// offered to the sibling compare block, which returns the target slot.
// Entries from that slot downward are then moved one place down,
// one slot per cycle, and the new score and id are written into the freed slot.
module topn_insert_buffer
  import topn_pkg::*;
#(
  parameter int width     = 8,
  parameter int id_width  = 8,
  parameter int quantity  = 10,
  parameter int idx_width = 4,
  parameter int timeout   = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear,
  input  logic                         score_valid,
  output logic                         score_ready,
  input  logic [width-1:0]             score_new,
  input  logic [id_width-1:0]          id_new,
  output logic                         compare_data_rdy,
  output logic [width-1:0]             score_in,
  output logic [quantity*width-1:0]    score_buffer,
  output logic [quantity*id_width-1:0] id_buffer,
  output logic [idx_width-1:0]         compare_num,
  input  logic                         compare_rdy,
  input  logic [idx_width-1:0]         insert_index,
  output logic                         insert_done,
  output logic                         insert_dropped,
  output logic                         timeout_err
);

  localparam int                    WAIT_W    = $clog2(timeout + 1);
  localparam logic [idx_width-1:0]  QTY       = idx_width'(quantity);
  localparam logic [WAIT_W-1:0]     WAIT_LAST = WAIT_W'(timeout - 1);

  state_t                r_state;
  state_t                w_next;
  logic [width-1:0]      r_score [quantity];
  logic [id_width-1:0]   r_id    [quantity];
  logic [width-1:0]      r_score_in;
  logic [id_width-1:0]   r_id_in;
  logic [idx_width-1:0]  r_num;
  logic [idx_width-1:0]  r_idx;
  logic [idx_width-1:0]  r_k;
  logic [WAIT_W-1:0]     r_wait;
  logic                  r_timeout_err;

  logic                  w_full;
  logic                  w_below;
  logic                  w_res_drop;
  logic [idx_width-1:0]  w_res_idx;
  logic [idx_width-1:0]  w_k_top;
  logic [idx_width-1:0]  w_km1;

  // Fill count saturates at the table depth; eviction keeps it there.
  function automatic logic [idx_width-1:0] sat_inc(input logic [idx_width-1:0] n);
    return (n >= QTY) ? QTY : n + 1'b1;
  endfunction

  // An index past the valid entries means "append"; with a full table there
  // is nowhere to append, so the score is dropped instead.
  assign w_full     = (r_num >= QTY);
  assign w_below    = (insert_index >= QTY) || (!w_full && (insert_index > r_num));
  assign w_res_drop = w_below && w_full;
  assign w_res_idx  = w_below ? r_num : insert_index;
  assign w_k_top    = idx_width'(slot_top(int'(r_num), quantity));
  assign w_km1      = r_k - 1'b1;

  assign score_ready      = (r_state == ST_IDLE) && !rst && !clear;
  assign compare_data_rdy = (r_state == ST_START);
  assign insert_done      = (r_state == ST_DONE);
  assign insert_dropped   = (r_state == ST_DROP);
  assign timeout_err      = r_timeout_err;
  assign score_in         = r_score_in;
  assign compare_num      = r_num;

  for (genvar g = 0; g < quantity; g++) begin : g_pack
    assign score_buffer[(g+1)*width-1 -: width]  = r_score[g];
    assign id_buffer[(g+1)*id_width-1 -: id_width] = r_id[g];
  end

  // State register; rst and clear both abort to IDLE.
  always_ff @(posedge clk) begin
    if (rst || clear) r_state <= ST_IDLE;
    else              r_state <= w_next;
  end

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:     if (score_valid) w_next = ST_START;
      ST_START:    w_next = ST_WAIT_CMP;
      ST_WAIT_CMP: begin
        if (compare_rdy) begin
          if (w_res_drop)             w_next = ST_DROP;
          else if (w_k_top > w_res_idx) w_next = ST_SHIFT;
          else                          w_next = ST_WRITE;
        end else if (r_wait == WAIT_LAST) begin
          w_next = ST_DROP;
        end
      end
      ST_SHIFT:    if (w_km1 == r_idx) w_next = ST_WRITE;
      ST_WRITE:    w_next = ST_DONE;
      ST_DONE:     w_next = ST_IDLE;
      ST_DROP:     w_next = ST_IDLE;
      default:     w_next = ST_IDLE;
    endcase
  end

  // Table, latched score, fill count, wait counter and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      for (int i = 0; i < quantity; i++) begin
        r_score[i] <= '0;
        r_id[i]    <= '0;
      end
      r_score_in    <= '0;
      r_id_in       <= '0;
      r_num         <= '0;
      r_idx         <= '0;
      r_k           <= '0;
      r_wait        <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (score_valid) begin
            r_score_in <= score_new;
            r_id_in    <= id_new;
          end
        end
        ST_START: r_wait <= '0;
        ST_WAIT_CMP: begin
          if (compare_rdy) begin
            r_idx <= w_res_idx;
            r_k   <= w_k_top;
          end else if (r_wait == WAIT_LAST) begin
            r_timeout_err <= 1'b1;
          end else begin
            r_wait <= r_wait + 1'b1;
          end
        end
        ST_SHIFT: begin
          r_score[r_k] <= r_score[w_km1];
          r_id[r_k]    <= r_id[w_km1];
          r_k          <= w_km1;
        end
        ST_WRITE: begin
          r_score[r_idx] <= r_score_in;
          r_id[r_idx]    <= r_id_in;
          r_num          <= sat_inc(r_num);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_topn_insert_buffer.sv
// Bench for topn_insert_buffer. The bench plays the compare block itself,
// answering each start pulse with a directed insert_index.
module tb_topn_insert_buffer;

  localparam int W  = 8;
  localparam int IW = 8;
  localparam int Q  = 10;
  localparam int XW = 4;
  localparam int TO = 64;

  logic            clk;
  logic            rst;
  logic            clear;
  logic            score_valid;
  logic            score_ready;
  logic [W-1:0]    score_new;
  logic [IW-1:0]   id_new;
  logic            compare_data_rdy;
  logic [W-1:0]    score_in;
  logic [Q*W-1:0]  score_buffer;
  logic [Q*IW-1:0] id_buffer;
  logic [XW-1:0]   compare_num;
  logic            compare_rdy;
  logic [XW-1:0]   insert_index;
  logic            insert_done;
  logic            insert_dropped;
  logic            timeout_err;

  topn_insert_buffer #(
    .width(W), .id_width(IW), .quantity(Q), .idx_width(XW), .timeout(TO)
  ) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .score_valid(score_valid), .score_ready(score_ready),
    .score_new(score_new), .id_new(id_new),
    .compare_data_rdy(compare_data_rdy), .score_in(score_in),
    .score_buffer(score_buffer), .id_buffer(id_buffer),
    .compare_num(compare_num), .compare_rdy(compare_rdy),
    .insert_index(insert_index), .insert_done(insert_done),
    .insert_dropped(insert_dropped), .timeout_err(timeout_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    bit              drop;
    logic [Q*W-1:0]  sb;
    logic [Q*IW-1:0] ib;
    int              num;
    bit              terr;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   m_sc[Q];
  int   m_id[Q];
  int   m_num;
  bit   m_terr;
  int   next_id = 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [Q*W-1:0] pack_sc(input int a[Q]);
    logic [Q*W-1:0] r;
    for (int i = 0; i < Q; i++) r[i*W +: W] = W'(a[i]);
    return r;
  endfunction

  function automatic logic [Q*IW-1:0] pack_id(input int a[Q]);
    logic [Q*IW-1:0] r;
    for (int i = 0; i < Q; i++) r[i*IW +: IW] = IW'(a[i]);
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < Q; i++) begin
      m_sc[i] = 0;
      m_id[i] = 0;
    end
    m_num  = 0;
    m_terr = 0;
  endtask

  task automatic push_exp(input bit drop);
    exp_t e;
    e.drop = drop;
    e.sb   = pack_sc(m_sc);
    e.ib   = pack_id(m_id);
    e.num  = m_num;
    e.terr = m_terr;
    q.push_back(e);
  endtask

  // Scoreboard monitor: every done/drop pulse consumes one expected entry.
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (insert_done || insert_dropped) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse: done=%0b dropped=%0b with nothing pending", insert_done, insert_dropped);
        end else begin
          e = q.pop_front();
          check("pulse_dropped", insert_dropped, e.drop);
          check("pulse_done", insert_done, !e.drop);
          check("sb_scores", score_buffer, e.sb);
          check("sb_ids", id_buffer, e.ib);
          check("sb_num", compare_num, e.num);
          check("sb_timeout_err", timeout_err, e.terr);
        end
      end
    end
  endtask

  // Present one score and follow it into the first WAIT_CMP cycle.
  task automatic offer(input int sc, input int id);
    int n = 0;
    while (!score_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) begin
      checks++; errors++;
      $display("FAIL ready_wait: score_ready stuck at %0b, required 1", score_ready);
    end
    score_valid = 1'b1;
    score_new   = W'(sc);
    id_new      = IW'(id);
    @(posedge clk); #1;
    score_valid = 1'b0;
    check("start_pulse", compare_data_rdy, 1'b1);
    check("score_in_latched", score_in, W'(sc));
    @(posedge clk); #1;
    check("start_one_cycle", compare_data_rdy, 1'b0);
  endtask

  // Insert through the compare handshake; idx_ovr >= 0 forces insert_index.
  task automatic insert(input int sc, input int idx_ovr);
    int p = 0;
    int top;
    int lat_exp;
    int lat = 0;
    bit drop;
    for (int i = 0; i < m_num; i++) if (m_sc[i] >= sc) p++;
    drop    = (p >= Q);
    top     = (m_num < Q) ? m_num : Q - 1;
    lat_exp = drop ? 1 : (top - p) + 2;
    if (!drop) begin
      for (int i = Q - 1; i > p; i--) begin
        m_sc[i] = m_sc[i-1];
        m_id[i] = m_id[i-1];
      end
      m_sc[p] = sc;
      m_id[p] = next_id % 256;
      if (m_num < Q) m_num++;
    end
    push_exp(drop);
    offer(sc, next_id % 256);
    next_id++;
    compare_rdy  = 1'b1;
    insert_index = XW'((idx_ovr >= 0) ? idx_ovr : p);
    do begin
      @(posedge clk); #1;
      compare_rdy = 1'b0;
      lat++;
    end while (!(insert_done || insert_dropped) && lat < 50);
    if (lat >= 50) begin
      checks++; errors++;
      $display("FAIL insert_wait: no done/drop after %0d cycles for score %0d", lat, sc);
    end else begin
      check("latency", lat, lat_exp);
    end
    @(posedge clk); #1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clk); #1;
    check("ready_in_clear", score_ready, 1'b0);
    clear = 1'b0;
    model_reset();
  endtask

  initial begin
    int t2[Q]   = '{14, 12, 11, 10, 8, 7, 7, 6, 5, 4};
    int e2[Q]   = '{14, 12, 11, 10, 9, 8, 7, 7, 6, 5};
    int t3[7]   = '{15, 12, 10, 9, 5, 4, 3};
    int e3[Q]   = '{15, 14, 12, 10, 9, 5, 4, 3, 0, 0};
    int e4[Q]   = '{9, 5, 3, 1, 1, 0, 0, 0, 0, 0};
    int zero[Q] = '{default: 0};
    int n;
    bit seen;

    rst = 1'b1; clear = 1'b0; score_valid = 1'b0; score_new = '0; id_new = '0;
    compare_rdy = 1'b0; insert_index = '0;
    model_reset();
    fork monitor(); join_none

    // Test 1: reset state, then a first insert into an empty table.
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("ready_in_rst", score_ready, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst_num", compare_num, 0);
    check("rst_scores", score_buffer, 0);
    check("rst_ids", id_buffer, 0);
    check("rst_ready", score_ready, 1'b1);
    check("rst_score_in", score_in, 0);
    check("rst_pulses", {compare_data_rdy, insert_done, insert_dropped, timeout_err}, 4'b0);
    insert(20, -1);
    check("t1_slot0", score_buffer[W-1:0], 20);
    check("t1_num", compare_num, 1);

    // Test 2: full table, mid insert evicts the minimum.
    do_clear();
    for (int i = 0; i < Q; i++) insert(t2[i], -1);
    insert(9, -1);
    check("t2_table", score_buffer, pack_sc(e2));
    check("t2_num", compare_num, Q);

    // Test 3: partial table, insert near the top.
    do_clear();
    for (int i = 0; i < 7; i++) insert(t3[i], -1);
    insert(14, -1);
    check("t3_table", score_buffer, pack_sc(e3));
    check("t3_num", compare_num, 8);

    // Test 4: below a full table drops; past a partial table appends.
    do_clear();
    for (int i = 0; i < Q; i++) insert(t2[i], -1);
    insert(2, 10);
    check("t4_unchanged", score_buffer, pack_sc(t2));
    do_clear();
    insert(9, -1); insert(5, -1); insert(3, -1);
    insert(1, 15);
    insert(1, 8);
    check("t4_append", score_buffer, pack_sc(e4));
    check("t4_num", compare_num, 5);

    // Test 5: compare never answers.
    m_terr = 1'b1;
    push_exp(1'b1);
    offer(50, next_id % 256);
    next_id++;
    n = 0;
    while (!insert_dropped && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("timeout_cycles", n, TO);
    check("timeout_flag", timeout_err, 1'b1);
    @(posedge clk); #1;
    check("timeout_idle", score_ready, 1'b1);
    check("timeout_table", score_buffer, pack_sc(e4));
    do_clear();
    check("timeout_cleared", timeout_err, 1'b0);

    // Test 6: clear during the shift sequence of test 2.
    for (int i = 0; i < Q; i++) insert(t2[i], -1);
    offer(9, 200);
    compare_rdy  = 1'b1;
    insert_index = 4'd4;
    @(posedge clk); #1;
    compare_rdy = 1'b0;
    @(posedge clk); #1;
    clear       = 1'b1;
    score_valid = 1'b1;
    score_new   = 8'd99;
    @(posedge clk); #1;
    check("t6_num", compare_num, 0);
    check("t6_scores", score_buffer, pack_sc(zero));
    check("t6_ids", id_buffer, 0);
    check("t6_ready_low", score_ready, 1'b0);
    @(posedge clk); #1;
    check("t6_no_start", compare_data_rdy, 1'b0);
    clear       = 1'b0;
    score_valid = 1'b0;
    model_reset();
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (compare_data_rdy || insert_done) seen = 1'b1;
    end
    check("t6_quiet", seen, 1'b0);
    check("t6_ready_back", score_ready, 1'b1);

    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("scoreboard_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
